// File: rtl/forward_scoreboard.sv
// forward_scoreboard: hazard unit for a 5-stage pipeline.
//   - Combinational operand-forwarding selects for the decode stage (branch
//     compare operands) and the execute stage.
//   - Load-use detection, which inserts one bubble into ID/EX.
//   - A two-state memory-wait FSM. It holds the pipeline for LOAD_LAT cycles
//     for every load that reaches the M stage.
// Optional feature: define FWD_PERF_CNT_EN to add the StallCycles and
// BubbleCount saturating performance counters.
// The CNT_W parameter must satisfy 2**CNT_W > LOAD_LAT.
//
// Handshake/timing note: there is no valid/ready interface here. Every
// output is valid in the same cycle as the inputs it depends on. The
// pipeline latches act on the stall/bubble outputs at the next rising CLK.
// While RST_N is low, every stall, bubble and select output is held at 0.
module forward_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] RsAddr_D,
  input  logic [ADDR_W-1:0] RtAddr_D,
  input  logic [ADDR_W-1:0] RsAddr_E,
  input  logic [ADDR_W-1:0] RtAddr_E,
  input  logic [ADDR_W-1:0] RegDstAddr_E,
  input  logic [ADDR_W-1:0] RegDstAddr_M,
  input  logic [ADDR_W-1:0] RegDstAddr_W,
  input  logic              RegWriteEN_E,
  input  logic              RegWriteEN_M,
  input  logic              RegWriteEN_W,
  input  logic              MemRead_E,
  input  logic              MemRead_M,
  output logic              STALL_FD,
  output logic              STALL_EM,
  output logic              BUBBLE_E,
  output logic              BUBBLE_W,
  output logic [1:0]        Fwd1AddrSEL_D,
  output logic [1:0]        Fwd2AddrSEL_D,
  output logic [1:0]        Fwd1AddrSEL_E,
  output logic [1:0]        Fwd2AddrSEL_E,
`ifdef FWD_PERF_CNT_EN
  output logic [15:0]       StallCycles,
  output logic [15:0]       BubbleCount,
`endif
  output logic [0:0]        fsm_state
);

  // FSM encoding
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // Latency-derived constants. With LOAD_LAT of 0 the memory never stalls.
  // With LOAD_LAT of 1 the detect cycle alone covers the whole wait.
  localparam bit HAS_LAT  = (LOAD_LAT > 0);
  localparam bit LAT_ONE  = (LOAD_LAT == 1);
  localparam int LAT_M1_I = (LOAD_LAT > 0) ? (LOAD_LAT - 1) : 0;
  localparam logic [CNT_W-1:0] LAT_M1  = LAT_M1_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Select encodings
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_NEAR = 2'd1;
  localparam logic [1:0] SEL_FAR  = 2'd2;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             served;
  logic             served_nxt;

  logic             mem_stall;
  logic             load_use;

  logic hit_e_rs_d;
  logic hit_e_rt_d;
  logic hit_m_rs_d;
  logic hit_m_rt_d;
  logic hit_m_rs_e;
  logic hit_m_rt_e;
  logic hit_w_rs_e;
  logic hit_w_rt_e;

  // A producer matches a consumer only if it writes, its destination is not
  // the hard-wired zero register, and the addresses are equal.
  function automatic logic hit(input logic en, input logic [ADDR_W-1:0] dst,
                               input logic [ADDR_W-1:0] src);
    return en && (dst != '0) && (dst == src);
  endfunction

  // Address comparators for every producer/consumer pair in use
  always_comb begin
    hit_e_rs_d = hit(RegWriteEN_E, RegDstAddr_E, RsAddr_D);
    hit_e_rt_d = hit(RegWriteEN_E, RegDstAddr_E, RtAddr_D);
    hit_m_rs_d = hit(RegWriteEN_M, RegDstAddr_M, RsAddr_D);
    hit_m_rt_d = hit(RegWriteEN_M, RegDstAddr_M, RtAddr_D);
    hit_m_rs_e = hit(RegWriteEN_M, RegDstAddr_M, RsAddr_E);
    hit_m_rt_e = hit(RegWriteEN_M, RegDstAddr_M, RtAddr_E);
    hit_w_rs_e = hit(RegWriteEN_W, RegDstAddr_W, RsAddr_E);
    hit_w_rt_e = hit(RegWriteEN_W, RegDstAddr_W, RtAddr_E);
  end

  // Stall sources.
  // The memory wait holds the pipeline for a fresh M-stage load and for the
  // whole MEM_WAIT state. Load-use stalls are masked while the memory wait
  // is active. They are evaluated again once the pipeline moves.
  always_comb begin
    mem_stall = 1'b0;
    load_use  = 1'b0;
    if (RST_N) begin
      mem_stall = ((state == ST_RUN) && MemRead_M && !served && HAS_LAT) ||
                  (state == ST_MEM_WAIT);
      load_use  = MemRead_E && (hit_e_rs_d || hit_e_rt_d) && !mem_stall;
    end
  end

  // Next-state logic for the memory-wait FSM
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    served_nxt = served;
    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          if (LAT_ONE) begin
            served_nxt = 1'b1;
          end else begin
            state_nxt = ST_MEM_WAIT;
            cnt_nxt   = LAT_M1;
          end
        end else begin
          // The load that was just served has moved on. The next load seen
          // in M is a new one.
          served_nxt = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        if (cnt <= CNT_ONE) begin
          state_nxt  = ST_RUN;
          cnt_nxt    = '0;
          served_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt  = ST_RUN;
        cnt_nxt    = '0;
        served_nxt = 1'b0;
      end
    endcase
  end

  // FSM state registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= ST_RUN;
      cnt    <= '0;
      served <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      served <= served_nxt;
    end
  end

  // Pipeline control outputs. The mem_stall and load_use terms are already
  // forced to 0 during reset.
  always_comb begin
    STALL_FD = mem_stall || load_use;
    STALL_EM = mem_stall;
    BUBBLE_E = load_use;
    BUBBLE_W = mem_stall;
  end

  // Forwarding selects.
  // In D: the E-stage ALU result has priority, but not while E holds a load,
  //       because the loaded data does not exist yet.
  // In E: the youngest producer (M) has priority over W.
  always_comb begin
    Fwd1AddrSEL_D = SEL_NONE;
    Fwd2AddrSEL_D = SEL_NONE;
    Fwd1AddrSEL_E = SEL_NONE;
    Fwd2AddrSEL_E = SEL_NONE;
    if (RST_N) begin
      if (hit_e_rs_d && !MemRead_E) Fwd1AddrSEL_D = SEL_NEAR;
      else if (hit_m_rs_d)          Fwd1AddrSEL_D = SEL_FAR;

      if (hit_e_rt_d && !MemRead_E) Fwd2AddrSEL_D = SEL_NEAR;
      else if (hit_m_rt_d)          Fwd2AddrSEL_D = SEL_FAR;

      if (hit_m_rs_e)      Fwd1AddrSEL_E = SEL_NEAR;
      else if (hit_w_rs_e) Fwd1AddrSEL_E = SEL_FAR;

      if (hit_m_rt_e)      Fwd2AddrSEL_E = SEL_NEAR;
      else if (hit_w_rt_e) Fwd2AddrSEL_E = SEL_FAR;
    end
  end

  // Expose the FSM state for observation
  always_comb begin
    fsm_state = state;
  end

`ifdef FWD_PERF_CNT_EN
  // Saturating counters: cycles lost to any stall, and bubbles injected
  // into ID/EX
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      StallCycles <= '0;
      BubbleCount <= '0;
    end else begin
      if ((mem_stall || load_use) && (StallCycles != 16'hFFFF))
        StallCycles <= StallCycles + 16'd1;
      if (load_use && (BubbleCount != 16'hFFFF))
        BubbleCount <= BubbleCount + 16'd1;
    end
  end
`endif

endmodule
